// File: rtl/vending_pkg.sv
// Shared constants, types and arithmetic helpers for the vending-machine controller.
package vending_pkg;

   localparam int kNumCoins   = 3;
   localparam int kNumItems   = 4;
   localparam int kTotalBits  = 31;
   localparam int kWaitTime   = 100;
   localparam int kMaxBalance = 10000;
   localparam int kTimerBits  = $clog2(kWaitTime + 1);

   typedef logic [kTotalBits-1:0] total_t;
   typedef logic [kTimerBits-1:0] timer_t;

   // Index 0 is the smallest value; the change picker relies on ascending order.
   localparam total_t kCoinValue [0:kNumCoins-1] = '{31'd100, 31'd500, 31'd1000};
   localparam total_t kItemPrice [0:kNumItems-1] = '{31'd400, 31'd500, 31'd1000, 31'd2000};

   localparam total_t kMaxBalanceT = total_t'(kMaxBalance);
   localparam timer_t kWaitTimeT   = timer_t'(kWaitTime);
   localparam timer_t kTimerOne    = timer_t'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      RETURN = 2'd2
   } state_t;

   function automatic total_t coin_sum(input logic [kNumCoins-1:0] coins);
      total_t sum;
      sum = '0;
      for (int i = 0; i < kNumCoins; i++) begin
         sum = sum + (coins[i] ? kCoinValue[i] : '0);
      end
      return sum;
   endfunction

   function automatic logic is_onehot(input logic [kNumItems-1:0] v);
      logic [kNumItems-1:0] seen;
      logic                 multi;
      seen  = '0;
      multi = 1'b0;
      for (int i = 0; i < kNumItems; i++) begin
         multi = multi | (v[i] & (|seen));
         seen  = seen | (v & (kNumItems'(1) << i));
      end
      return (|v) & ~multi;
   endfunction

endpackage

// File: rtl/change_picker.sv
// Greedy change selector: largest coin whose value fits in the balance, as one-hot plus value.
module change_picker
   import vending_pkg::*;
(
   input  logic [kTotalBits-1:0] i_balance,
   output logic [kNumCoins-1:0]  o_coin,
   output logic [kTotalBits-1:0] o_value
);

   // Ascending scan: each fitting larger coin overrides the previous pick.
   always_comb begin
      o_coin  = '0;
      o_value = '0;
      for (int i = 0; i < kNumCoins; i++) begin
         if (kCoinValue[i] <= i_balance) begin
            o_coin    = '0;
            o_coin[i] = 1'b1;
            o_value   = kCoinValue[i];
         end else begin
            o_coin  = o_coin;
            o_value = o_value;
         end
      end
   end

endmodule

// File: rtl/vending_ctrl.sv
// Vending-machine sequencing controller: balance, coin/selection handling,
// idle timeout and one-coin-per-cycle greedy change return.
module vending_ctrl
   import vending_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [kNumCoins-1:0]  i_input_coin,
   input  logic [kNumItems-1:0]  i_select_item,
   input  logic                  i_trigger_return,
   output logic [kNumItems-1:0]  o_available_item,
   output logic [kNumItems-1:0]  o_output_item,
   output logic [kNumCoins-1:0]  o_return_coin,
   output logic                  o_reject,
   output logic [kTotalBits-1:0] o_current_total,
   output logic                  o_busy
);

   state_t                  r_state,       w_state_n;
   logic [kTotalBits-1:0]   r_balance,     w_balance_n;
   logic [kTimerBits-1:0]   r_timer,       w_timer_n;
   logic [kNumItems-1:0]    r_output_item, w_output_item_n;
   logic [kNumCoins-1:0]    r_return_coin, w_return_coin_n;
   logic                    r_reject,      w_reject_n;

   logic [kTotalBits-1:0]   w_coin_sum, w_after_coin, w_price, w_change_value;
   logic [kNumCoins-1:0]    w_change_coin;
   logic                    w_coin_any, w_coin_ok, w_sel_ok, w_reload;

   change_picker u_change_picker (
      .i_balance (r_balance),
      .o_coin    (w_change_coin),
      .o_value   (w_change_value)
   );

   assign w_coin_sum   = coin_sum(i_input_coin);
   assign w_coin_any   = |i_input_coin;
   assign w_after_coin = r_balance + w_coin_sum;
   assign w_coin_ok    = w_coin_any && (r_state != RETURN) && (w_after_coin <= kMaxBalanceT);
   // Affordability uses the balance before this cycle's coins.
   assign w_sel_ok     = (r_state == ACCEPT) && is_onehot(i_select_item) && (w_price <= r_balance);
   assign w_reload     = w_coin_ok || w_sel_ok;

   // Price of the requested item; only meaningful when the request is one-hot.
   always_comb begin
      w_price = '0;
      for (int i = 0; i < kNumItems; i++) begin
         w_price = w_price | (i_select_item[i] ? kItemPrice[i] : '0);
      end
   end

   // Next-state, balance, timer and output-pulse logic.
   always_comb begin
      w_state_n       = r_state;
      w_balance_n     = r_balance;
      w_timer_n       = r_timer;
      w_output_item_n = '0;
      w_return_coin_n = '0;
      w_reject_n      = w_coin_any && !w_coin_ok;
      case (r_state)
         IDLE: begin
            w_timer_n = kWaitTimeT;
            if (w_coin_ok) begin
               w_balance_n = w_after_coin;
               w_state_n   = ACCEPT;
            end else begin
               w_balance_n = r_balance;
            end
         end
         ACCEPT: begin
            w_balance_n     = (w_coin_ok ? w_after_coin : r_balance) - (w_sel_ok ? w_price : '0);
            w_output_item_n = w_sel_ok ? i_select_item : '0;
            if (w_balance_n == '0) begin
               w_state_n = IDLE;
               w_timer_n = kWaitTimeT;
            end else if (i_trigger_return || ((r_timer == '0) && !w_reload)) begin
               w_state_n = RETURN;
               w_timer_n = kWaitTimeT;
            end else if (w_reload) begin
               w_timer_n = kWaitTimeT;
            end else begin
               w_timer_n = r_timer - kTimerOne;
            end
         end
         RETURN: begin
            w_return_coin_n = w_change_coin;
            w_balance_n     = r_balance - w_change_value;
            if (w_balance_n == '0) begin
               w_state_n = IDLE;
            end else begin
               w_state_n = RETURN;
            end
         end
         default: begin
            w_state_n   = IDLE;
            w_balance_n = '0;
            w_timer_n   = kWaitTimeT;
         end
      endcase
   end

   // State and registered-output update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_balance     <= '0;
         r_timer       <= kWaitTimeT;
         r_output_item <= '0;
         r_return_coin <= '0;
         r_reject      <= 1'b0;
      end else begin
         r_state       <= w_state_n;
         r_balance     <= w_balance_n;
         r_timer       <= w_timer_n;
         r_output_item <= w_output_item_n;
         r_return_coin <= w_return_coin_n;
         r_reject      <= w_reject_n;
      end
   end

   // Items affordable from the current balance, suppressed while paying change.
   always_comb begin
      o_available_item = '0;
      for (int i = 0; i < kNumItems; i++) begin
         o_available_item[i] = (kItemPrice[i] <= r_balance) && (r_state != RETURN);
      end
   end

   assign o_output_item   = r_output_item;
   assign o_return_coin   = r_return_coin;
   assign o_reject        = r_reject;
   assign o_current_total = r_balance;
   assign o_busy          = (r_state == RETURN);

endmodule

// File: tb/tb_vending_ctrl.sv
// Scoreboard bench for vending_ctrl: each driven cycle pushes its expected outputs.
module tb_vending_ctrl;

   typedef struct packed {
      logic [3:0]  item;
      logic [2:0]  coin;
      logic        rej;
      logic [30:0] total;
      logic        busy;
      logic [3:0]  avail;
   } obs_t;

   typedef struct packed {
      logic [2:0]  coin;
      logic [3:0]  sel;
      logic        ret;
      logic [3:0]  item;
      logic [2:0]  rc;
      logic        rej;
      logic [30:0] total;
      logic        busy;
   } row_t;

   localparam int unsigned PRICE [4] = '{400, 500, 1000, 2000};

   logic        clk;
   logic        reset;
   logic [2:0]  i_input_coin;
   logic [3:0]  i_select_item;
   logic        i_trigger_return;
   logic [3:0]  o_available_item;
   logic [3:0]  o_output_item;
   logic [2:0]  o_return_coin;
   logic        o_reject;
   logic [30:0] o_current_total;
   logic        o_busy;

   obs_t sb[$];
   int   n_checks;
   int   n_pass;

   vending_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .i_input_coin     (i_input_coin),
      .i_select_item    (i_select_item),
      .i_trigger_return (i_trigger_return),
      .o_available_item (o_available_item),
      .o_output_item    (o_output_item),
      .o_return_coin    (o_return_coin),
      .o_reject         (o_reject),
      .o_current_total  (o_current_total),
      .o_busy           (o_busy)
   );

   always #5 clk = ~clk;

   function automatic row_t r(input logic [2:0] coin, input logic [3:0] sel, input logic ret,
                              input logic [3:0] item, input logic [2:0] rc, input logic rej,
                              input int unsigned total, input logic busy);
      row_t x;
      x.coin  = coin;
      x.sel   = sel;
      x.ret   = ret;
      x.item  = item;
      x.rc    = rc;
      x.rej   = rej;
      x.total = 31'(total);
      x.busy  = busy;
      return x;
   endfunction

   function automatic obs_t mk(input row_t x);
      obs_t e;
      e.item  = x.item;
      e.coin  = x.rc;
      e.rej   = x.rej;
      e.total = x.total;
      e.busy  = x.busy;
      for (int i = 0; i < 4; i++) begin
         e.avail[i] = !x.busy && (PRICE[i] <= 32'(x.total));
      end
      return e;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.item  = o_output_item;
      o.coin  = o_return_coin;
      o.rej   = o_reject;
      o.total = o_current_total;
      o.busy  = o_busy;
      o.avail = o_available_item;
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("item=%b coin=%b rej=%b total=%0d busy=%b avail=%b",
                       o.item, o.coin, o.rej, o.total, o.busy, o.avail);
   endfunction

   task automatic apply(input row_t x);
      i_input_coin     = x.coin;
      i_select_item    = x.sel;
      i_trigger_return = x.ret;
      sb.push_back(mk(x));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      row_t rows[$];
      obs_t exp_o, obs_o;
      reset        = 1'b1;
      i_input_coin = 3'b111;
      sb.push_back(mk(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 0, 1'b0)));
      repeat (2) @(posedge clk);
      #1;
      exp_o = sb.pop_front();
      obs_o = sample();
      n_checks++;
      if (obs_o !== exp_o) $display("FAIL reset_state: got %s, expected %s", fmt(obs_o), fmt(exp_o));
      else n_pass++;
      @(negedge clk);
      reset        = 1'b0;
      i_input_coin = 3'b000;
      rows.push_back(r(3'b000, 4'b0000, 1'b1, 4'b0000, 3'b000, 1'b0, 0, 1'b0));
      rows.push_back(r(3'b000, 4'b0001, 1'b0, 4'b0000, 3'b000, 1'b0, 0, 1'b0));
      foreach (rows[k]) begin
         apply(rows[k]);
         exp_o = sb.pop_front();
         obs_o = sample();
         n_checks++;
         if (obs_o !== exp_o) $display("FAIL idle_ignore[%0d]: got %s, expected %s", k, fmt(obs_o), fmt(exp_o));
         else n_pass++;
      end
   endtask

   task automatic test_buy_and_return();
      row_t rows[$];
      obs_t exp_o, obs_o;
      rows.push_back(r(3'b010, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0,  500, 1'b0));
      rows.push_back(r(3'b001, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0,  600, 1'b0));
      rows.push_back(r(3'b000, 4'b0001, 1'b0, 4'b0001, 3'b000, 1'b0,  200, 1'b0));
      rows.push_back(r(3'b000, 4'b0000, 1'b1, 4'b0000, 3'b000, 1'b0,  200, 1'b1));
      rows.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b001, 1'b0,  100, 1'b1));
      rows.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b001, 1'b0,    0, 1'b0));
      rows.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0,    0, 1'b0));
      foreach (rows[k]) begin
         apply(rows[k]);
         exp_o = sb.pop_front();
         obs_o = sample();
         n_checks++;
         if (obs_o !== exp_o) $display("FAIL buy_return[%0d]: got %s, expected %s", k, fmt(obs_o), fmt(exp_o));
         else n_pass++;
      end
   endtask

   task automatic test_multi_coin();
      row_t rows[$];
      obs_t exp_o, obs_o;
      rows.push_back(r(3'b110, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1500, 1'b0));
      rows.push_back(r(3'b000, 4'b0000, 1'b1, 4'b0000, 3'b000, 1'b0, 1500, 1'b1));
      rows.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b100, 1'b0,  500, 1'b1));
      rows.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b010, 1'b0,    0, 1'b0));
      foreach (rows[k]) begin
         apply(rows[k]);
         exp_o = sb.pop_front();
         obs_o = sample();
         n_checks++;
         if (obs_o !== exp_o) $display("FAIL multi_coin[%0d]: got %s, expected %s", k, fmt(obs_o), fmt(exp_o));
         else n_pass++;
      end
   endtask

   task automatic test_ceiling();
      row_t rows[$];
      obs_t exp_o, obs_o;
      rows.push_back(r(3'b110, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1500, 1'b0));
      for (int k = 1; k <= 8; k++) begin
         rows.push_back(r(3'b100, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1500 + 1000 * k, 1'b0));
      end
      rows.push_back(r(3'b100, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b1,  9500, 1'b0));
      rows.push_back(r(3'b000, 4'b0011, 1'b0, 4'b0000, 3'b000, 1'b0,  9500, 1'b0));
      rows.push_back(r(3'b010, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 10000, 1'b0));
      rows.push_back(r(3'b001, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b1, 10000, 1'b0));
      rows.push_back(r(3'b000, 4'b0000, 1'b1, 4'b0000, 3'b000, 1'b0, 10000, 1'b1));
      for (int k = 1; k <= 10; k++) begin
         rows.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b100, 1'b0, 10000 - 1000 * k, (k != 10)));
      end
      foreach (rows[k]) begin
         apply(rows[k]);
         exp_o = sb.pop_front();
         obs_o = sample();
         n_checks++;
         if (obs_o !== exp_o) $display("FAIL ceiling[%0d]: got %s, expected %s", k, fmt(obs_o), fmt(exp_o));
         else n_pass++;
      end
   endtask

   task automatic test_timeout();
      row_t rows[$];
      obs_t exp_o, obs_o;
      rows.push_back(r(3'b010, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 500, 1'b0));
      for (int k = 0; k < 100; k++) begin
         rows.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 500, 1'b0));
      end
      rows.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 500, 1'b1));
      rows.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b010, 1'b0,   0, 1'b0));
      foreach (rows[k]) begin
         apply(rows[k]);
         exp_o = sb.pop_front();
         obs_o = sample();
         n_checks++;
         if (obs_o !== exp_o) $display("FAIL timeout[%0d]: got %s, expected %s", k, fmt(obs_o), fmt(exp_o));
         else n_pass++;
      end
   endtask

   task automatic test_coin_and_select();
      row_t rows[$];
      obs_t exp_o, obs_o;
      rows.push_back(r(3'b100, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1000, 1'b0));
      rows.push_back(r(3'b010, 4'b1000, 1'b0, 4'b0000, 3'b000, 1'b0, 1500, 1'b0));
      rows.push_back(r(3'b001, 4'b0100, 1'b0, 4'b0100, 3'b000, 1'b0,  600, 1'b0));
      rows.push_back(r(3'b000, 4'b0000, 1'b1, 4'b0000, 3'b000, 1'b0,  600, 1'b1));
      rows.push_back(r(3'b001, 4'b0001, 1'b1, 4'b0000, 3'b010, 1'b1,  100, 1'b1));
      rows.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b001, 1'b0,    0, 1'b0));
      foreach (rows[k]) begin
         apply(rows[k]);
         exp_o = sb.pop_front();
         obs_o = sample();
         n_checks++;
         if (obs_o !== exp_o) $display("FAIL coin_select[%0d]: got %s, expected %s", k, fmt(obs_o), fmt(exp_o));
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      row_t rows[$];
      obs_t exp_o, obs_o;
      rows.push_back(r(3'b110, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1500, 1'b0));
      rows.push_back(r(3'b000, 4'b0100, 1'b0, 4'b0100, 3'b000, 1'b0,  500, 1'b0));
      rows.push_back(r(3'b000, 4'b0010, 1'b0, 4'b0010, 3'b000, 1'b0,    0, 1'b0));
      rows.push_back(r(3'b000, 4'b0000, 1'b1, 4'b0000, 3'b000, 1'b0,    0, 1'b0));
      rows.push_back(r(3'b001, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0,  100, 1'b0));
      foreach (rows[k]) begin
         apply(rows[k]);
         exp_o = sb.pop_front();
         obs_o = sample();
         n_checks++;
         if (obs_o !== exp_o) $display("FAIL back_to_back[%0d]: got %s, expected %s", k, fmt(obs_o), fmt(exp_o));
         else n_pass++;
      end
   endtask

   // Starts from a balance of 100 in ACCEPT.
   task automatic test_reset_mid_return();
      row_t rows[$];
      row_t post[$];
      obs_t exp_o, obs_o;
      rows.push_back(r(3'b110, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1600, 1'b0));
      rows.push_back(r(3'b000, 4'b0000, 1'b1, 4'b0000, 3'b000, 1'b0, 1600, 1'b1));
      rows.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b100, 1'b0,  600, 1'b1));
      foreach (rows[k]) begin
         apply(rows[k]);
         exp_o = sb.pop_front();
         obs_o = sample();
         n_checks++;
         if (obs_o !== exp_o) $display("FAIL mid_return[%0d]: got %s, expected %s", k, fmt(obs_o), fmt(exp_o));
         else n_pass++;
      end
      i_input_coin     = 3'b000;
      i_select_item    = 4'b0000;
      i_trigger_return = 1'b0;
      reset = 1'b1;
      sb.push_back(mk(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 0, 1'b0)));
      #1;
      exp_o = sb.pop_front();
      obs_o = sample();
      n_checks++;
      if (obs_o !== exp_o) $display("FAIL async_reset: got %s, expected %s", fmt(obs_o), fmt(exp_o));
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      post.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0,    0, 1'b0));
      post.push_back(r(3'b100, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1000, 1'b0));
      for (int k = 0; k < 100; k++) begin
         post.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1000, 1'b0));
      end
      post.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1000, 1'b1));
      post.push_back(r(3'b000, 4'b0000, 1'b0, 4'b0000, 3'b100, 1'b0,    0, 1'b0));
      foreach (post[k]) begin
         apply(post[k]);
         exp_o = sb.pop_front();
         obs_o = sample();
         n_checks++;
         if (obs_o !== exp_o) $display("FAIL after_reset[%0d]: got %s, expected %s", k, fmt(obs_o), fmt(exp_o));
         else n_pass++;
      end
   endtask

   initial begin
      clk              = 1'b0;
      reset            = 1'b1;
      i_input_coin     = 3'b000;
      i_select_item    = 4'b0000;
      i_trigger_return = 1'b0;
      n_checks         = 0;
      n_pass           = 0;
      test_reset();
      test_buy_and_return();
      test_multi_coin();
      test_ceiling();
      test_timeout();
      test_coin_and_select();
      test_back_to_back();
      test_reset_mid_return();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
